player_select_ctrl: RTL and testbench
=====================================

// Module: player_select_ctrl
// PURPOSE
//  Front-end controller that drives the 2-bit player-selection code consumed by the sprite print mux.
//  Debounces the board push-buttons once per video frame and runs the select/confirm FSM.
//  Produces the selection code, the lock flag, the blink enable and the sprite anchor position.
//  Sits between the button pins and the sprite/VGA path, clocked by the pixel clock.
// PARAMETERS
//  DEBOUNCE_FRAMES  3       consecutive frame_tick samples a raw button must differ before accepted (>=1)
//  BLINK_FRAMES     15      frame_ticks per blink half-period while choosing (>=1)
//  POS_X            10'd280 sprite anchor X driven on posX
//  POS_Y            10'd200 sprite anchor Y driven on posY
// PORTS
//  clk                     in   1   pixel clock; all state on posedge
//  rst                     in   1   asynchronous, active-high reset
//  frame_tick              in   1   one-clk pulse per frame (start of vertical blank)
//  btn_next                in   1   raw button, active-high, asynchronous to clk
//  btn_prev                in   1   raw button, active-high
//  btn_ok                  in   1   raw button, active-high
//  btn_back                in   1   raw button, active-high
//  contador_seleccionador  out  2   00 none, 01 player 1 (Rick), 10 player 2 (Morty); 11 never driven
//  locked                  out  1   1 while selection confirmed
//  blink_on                out  1   sprite visibility gate
//  posX                    out  10  sprite anchor X (constant POS_X)
//  posY                    out  10  sprite anchor Y (constant POS_Y)
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE, contador_seleccionador=00, locked=0, blink_on=0,
//   stable button regs=0, debounce and blink counters=0, posX=POS_X, posY=POS_Y. Mid-operation reset aborts immediately.
//  Input sync: each btn_* passes a 2-FF synchronizer before debounce.
//  Debounce, per button, evaluated only on cycles with frame_tick=1:
//   synced != stable -> cnt++; when cnt reaches DEBOUNCE_FRAMES, stable<=synced, cnt<=0.
//   synced == stable -> cnt<=0. Between ticks counters hold.
//  Press event: one-clk pulse on the cycle after stable rises 0->1; release produces no event.
//  Event priority when several fire in one cycle: back > ok > next > prev (only highest acts).
//  FSM (transition on the clk edge after the event pulse; outputs registered):
//   IDLE:   next -> CHOOSE, sel=01; prev -> CHOOSE, sel=10; ok/back ignored. blink_on=0, locked=0.
//   CHOOSE: next or prev -> toggle sel 01<->10 (wrap, two players); ok -> LOCKED;
//           back -> IDLE, sel=00. locked=0.
//   LOCKED: back -> CHOOSE, sel kept; next/prev/ok ignored. locked=1, blink_on=1.
//  Blink in CHOOSE: on entry blink_cnt=0, blink_on=1; each frame_tick blink_cnt++;
//   at BLINK_FRAMES-1 with frame_tick, blink_cnt<=0 and blink_on toggles. Selection change resets blink_cnt, blink_on=1.
//  Latency: stable button edge -> sel change = 2 clk (event pulse, then state register).
//  Total press-to-select = 2 sync clk + DEBOUNCE_FRAMES frame_ticks + 2 clk.
//  Invariant: contador_seleccionador==00 iff state IDLE; 11 is unreachable.
// TESTING
//  T1 reset: assert rst mid-CHOOSE asynchronously -> outputs 00/0/0 same cycle, posX=280, posY=200.
//  T2 debounce: btn_next high for 2 frame_ticks then low -> no change; high 3 ticks -> sel 00->01 within 2 clk after 3rd tick.
//  T3 wrap: IDLE, next -> 01; next -> 10; next -> 01; prev -> 10; never 11.
//  T4 confirm/back: sel=10, ok -> locked=1, blink_on=1; next ignored; back -> CHOOSE sel=10; back -> IDLE sel=00.
//  T5 priority: ok and back stable-rise same frame in CHOOSE -> IDLE, locked stays 0.
//  T6 blink: in CHOOSE, BLINK_FRAMES=15 -> blink_on toggles after every 15 frame_ticks; no toggle without frame_tick.

Source files
------------

// File: rtl/player_select_ctrl_if.sv
// Button/frame inputs and selection outputs shared by the select controller and the sprite path.
interface player_select_ctrl_if;
  logic       frame_tick;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_ok;
  logic       btn_back;
  logic [1:0] contador_seleccionador;
  logic       locked;
  logic       blink_on;
  logic [9:0] posX;
  logic [9:0] posY;

  modport master (
    output frame_tick, btn_next, btn_prev, btn_ok, btn_back,
    input  contador_seleccionador, locked, blink_on, posX, posY
  );

  modport slave (
    input  frame_tick, btn_next, btn_prev, btn_ok, btn_back,
    output contador_seleccionador, locked, blink_on, posX, posY
  );
endinterface

// File: rtl/player_select_ctrl.sv
// Player select/confirm controller: per-frame button debounce feeding a select FSM that
// drives the sprite mux code, lock flag and blink gate.
//
// state  | meaning
// IDLE   | nobody selected, sprite hidden
// CHOOSE | player highlighted, sprite blinking, next/prev cycle the choice
// LOCKED | choice confirmed, sprite solid
module player_select_ctrl #(
  parameter int         DEBOUNCE_FRAMES = 3,
  parameter int         BLINK_FRAMES    = 15,
  parameter logic [9:0] POS_X           = 10'd280,
  parameter logic [9:0] POS_Y           = 10'd200
) (
  input  logic               clk,
  input  logic               rst,
  player_select_ctrl_if.slave bus
);

  localparam int DCW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int BCW = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, CHOOSE, LOCKED} state_t;

  // bit order: 0 next, 1 prev, 2 ok, 3 back
  logic [3:0]     raw;
  logic [3:0]     sync1, sync2, stable, stable_d, ev;
  logic [DCW-1:0] dcnt [4];

  assign raw = {bus.btn_back, bus.btn_ok, bus.btn_prev, bus.btn_next};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      ev       <= '0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      ev       <= stable & ~stable_d;
      if (bus.frame_tick) begin
        for (int i = 0; i < 4; i++) begin
          if (sync2[i] != stable[i]) begin
            if (dcnt[i] == DCW'(DEBOUNCE_FRAMES - 1)) begin
              stable[i] <= sync2[i];
              dcnt[i]   <= '0;
            end else begin
              dcnt[i] <= dcnt[i] + 1'b1;
            end
          end else begin
            dcnt[i] <= '0;
          end
        end
      end
    end
  end

  // Only the highest-priority event of a cycle is seen by the FSM, even if it is ignored there.
  logic go_back, go_ok, go_next, go_prev;
  assign go_back = ev[3];
  assign go_ok   = ev[2] & ~ev[3];
  assign go_next = ev[0] & ~|ev[3:2];
  assign go_prev = ev[1] & ~ev[0] & ~|ev[3:2];

  state_t         state, state_n;
  logic [1:0]     sel, sel_n;
  logic           locked, locked_n;
  logic           blink_on, blink_n;
  logic [BCW-1:0] bcnt, bcnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 2'b00;
      locked   <= 1'b0;
      blink_on <= 1'b0;
      bcnt     <= '0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      locked   <= locked_n;
      blink_on <= blink_n;
      bcnt     <= bcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    blink_n = blink_on;
    bcnt_n  = bcnt;
    unique case (state)
      IDLE: begin
        blink_n = 1'b0;
        bcnt_n  = '0;
        if (go_next || go_prev) begin
          state_n = CHOOSE;
          sel_n   = go_next ? 2'b01 : 2'b10;
          blink_n = 1'b1;
        end
      end
      CHOOSE: begin
        if (go_back) begin
          state_n = IDLE;
          sel_n   = 2'b00;
          blink_n = 1'b0;
          bcnt_n  = '0;
        end else if (go_ok) begin
          state_n = LOCKED;
          blink_n = 1'b1;
          bcnt_n  = '0;
        end else if (go_next || go_prev) begin
          sel_n   = {sel[0], sel[1]};
          blink_n = 1'b1;
          bcnt_n  = '0;
        end else if (bus.frame_tick) begin
          if (bcnt == BCW'(BLINK_FRAMES - 1)) begin
            bcnt_n  = '0;
            blink_n = ~blink_on;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end
      end
      LOCKED: begin
        blink_n = 1'b1;
        bcnt_n  = '0;
        if (go_back) state_n = CHOOSE;
      end
      default: begin
        state_n = IDLE;
        sel_n   = 2'b00;
        blink_n = 1'b0;
        bcnt_n  = '0;
      end
    endcase
    locked_n = (state_n == LOCKED);
  end

  assign bus.contador_seleccionador = sel;
  assign bus.locked                 = locked;
  assign bus.blink_on               = blink_on;
  assign bus.posX                   = POS_X;
  assign bus.posY                   = POS_Y;

endmodule

// File: tb/tb_player_select_ctrl.sv
// Randomized bench for player_select_ctrl against a frame/tick-level behavioural model.
module tb_player_select_ctrl;
  localparam int DEB = 3;
  localparam int BF  = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = 4'b0000;   // 0 next, 1 prev, 2 ok, 3 back
  logic       tick = 1'b0;

  always #5 clk = ~clk;

  player_select_ctrl_if bus();
  assign bus.frame_tick = tick;
  assign bus.btn_next   = raw[0];
  assign bus.btn_prev   = raw[1];
  assign bus.btn_ok     = raw[2];
  assign bus.btn_back   = raw[3];

  player_select_ctrl #(.DEBOUNCE_FRAMES(DEB), .BLINK_FRAMES(BF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: mode 0 none / 1 choosing / 2 confirmed; player 1 or 2; ticks counted since
  // entering choosing or changing player. Accepted presses act two clocks later.
  int m_s1[4], m_s2[4], m_stab[4], m_cnt[4];
  int due_q[$];
  int btn_q[$];
  int m_mode, m_player, m_ticks, m_cyc;

  task automatic m_reset();
    for (int b = 0; b < 4; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_cnt[b] = 0;
    end
    due_q.delete();
    btn_q.delete();
    m_mode = 0; m_player = 0; m_ticks = 0;
  endtask

  task automatic m_step(input logic [3:0] r, input logic t);
    int fire[4];
    int act;
    bit restart;
    for (int b = 0; b < 4; b++) fire[b] = 0;
    for (int i = due_q.size() - 1; i >= 0; i--) begin
      if (due_q[i] == m_cyc) begin
        fire[btn_q[i]] = 1;
        due_q.delete(i);
        btn_q.delete(i);
      end
    end
    if (t) begin
      for (int b = 0; b < 4; b++) begin
        if (m_s2[b] != m_stab[b]) begin
          m_cnt[b]++;
          if (m_cnt[b] == DEB) begin
            m_stab[b] = m_s2[b];
            m_cnt[b] = 0;
            if (m_stab[b] == 1) begin
              due_q.push_back(m_cyc + 2);
              btn_q.push_back(b);
            end
          end
        end else begin
          m_cnt[b] = 0;
        end
      end
    end
    for (int b = 0; b < 4; b++) begin
      m_s2[b] = m_s1[b];
      m_s1[b] = int'(r[b]);
    end
    act = fire[3] ? 3 : fire[2] ? 2 : fire[0] ? 0 : fire[1] ? 1 : -1;
    restart = 0;
    case (m_mode)
      0: if (act == 0 || act == 1) begin
           m_mode = 1; m_player = (act == 0) ? 1 : 2; restart = 1;
         end
      1: if (act == 3) m_mode = 0;
         else if (act == 2) m_mode = 2;
         else if (act == 0 || act == 1) begin
           m_player = 3 - m_player; restart = 1;
         end
      default: if (act == 3) begin m_mode = 1; restart = 1; end
    endcase
    if (restart) m_ticks = 0;
    else if (m_mode == 1 && t) m_ticks++;
    m_cyc++;
  endtask

  function automatic int m_sel();
    return (m_mode == 0) ? 0 : m_player;
  endfunction

  function automatic int m_blink();
    if (m_mode == 2) return 1;
    if (m_mode == 1) return (((m_ticks / BF) % 2) == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) m_reset();
    else m_step(raw, tick);
    @(negedge clk);
    chk("sel", 32'(bus.contador_seleccionador), 32'(m_sel()));
    chk("locked", 32'(bus.locked), (m_mode == 2) ? 32'd1 : 32'd0);
    chk("blink", 32'(bus.blink_on), 32'(m_blink()));
  endtask

  task automatic hold(input logic [3:0] r, input int n);
    raw = r;
    for (int k = 0; k < n; k++) begin
      tick = 1'b0;
      repeat (3) step();
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
  endtask

  task automatic press(input logic [3:0] r);
    hold(r, 4);
    hold(4'b0000, 4);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_sel", 32'(bus.contador_seleccionador), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_blink", 32'(bus.blink_on), 32'd0);
    chk("rst_posx", 32'(bus.posX), 32'd280);
    chk("rst_posy", 32'(bus.posY), 32'd200);
    m_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    m_cyc = 0;
    step();
    step();
    rst = 1'b0;

    // short glitch rejected, then a 3-frame press selects two clocks after the last tick
    hold(4'b0001, 2);
    hold(4'b0000, 3);
    chk("glitch_ignored", 32'(bus.contador_seleccionador), 32'd0);
    hold(4'b0001, 3);
    step();
    step();
    chk("press_latency", 32'(bus.contador_seleccionador), 32'd1);
    hold(4'b0000, 4);

    // asynchronous reset while choosing
    do_reset();

    press(4'b0001); chk("wrap_a", 32'(bus.contador_seleccionador), 32'd1);
    press(4'b0001); chk("wrap_b", 32'(bus.contador_seleccionador), 32'd2);
    press(4'b0001); chk("wrap_c", 32'(bus.contador_seleccionador), 32'd1);
    press(4'b0010); chk("wrap_d", 32'(bus.contador_seleccionador), 32'd2);

    press(4'b0100); chk("ok_lock", 32'(bus.locked), 32'd1);
    chk("ok_blink", 32'(bus.blink_on), 32'd1);
    press(4'b0001); chk("locked_next_ign", 32'(bus.contador_seleccionador), 32'd2);
    press(4'b1000); chk("back_sel", 32'(bus.contador_seleccionador), 32'd2);
    chk("back_unlock", 32'(bus.locked), 32'd0);
    press(4'b1000); chk("back_idle", 32'(bus.contador_seleccionador), 32'd0);

    press(4'b0001);
    press(4'b1100); chk("prio_sel", 32'(bus.contador_seleccionador), 32'd0);
    chk("prio_locked", 32'(bus.locked), 32'd0);

    // long idle stretch in CHOOSE exercises several blink half-periods
    press(4'b0010);
    hold(4'b0000, 40);

    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 49) == 0) raw[b] = ~raw[b];
      tick = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1499) == 0) do_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
